// File: rtl/hs_rr_arbiter_if.sv
// Shared valid/ready channel between NUM_REQ upstream requesters and one downstream sink.
// The arbiter connects through the slave modport; the environment driving it uses master.
interface hs_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        s_valid;
  logic [NUM_REQ*DATA_W-1:0] s_data;
  logic [NUM_REQ-1:0]        s_ready;
  logic                      m_valid;
  logic [DATA_W-1:0]         m_data;
  logic                      m_ready;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter locking one requester onto a shared valid/ready channel per beat.
// Optional stall watchdog enabled by defining HS_ARB_TIMEOUT_EN.
module hs_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  hs_rr_arbiter_if.slave     bus,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [7:0]         xfer_cnt,
  output logic               timeout_err
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_cfg
    $error("hs_rr_arbiter: unsupported NUM_REQ/TIMEOUT");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         xfer_cnt_q, xfer_cnt_d;
  logic [IDX_W-1:0]   cand_idx, win_idx, gnt_idx;
  logic               win_found, in_grant, handshake;
`ifdef HS_ARB_TIMEOUT_EN
  logic [7:0]         stall_q, stall_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Scan starts just after the last winner, so it is checked last next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.s_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_q[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign in_grant    = (state_q == GRANT) && !sys_rst;
  assign bus.m_valid = in_grant && |(bus.s_valid & grant_oh_q);
  assign bus.s_ready = (in_grant && bus.m_ready) ? grant_oh_q : '0;
  assign handshake   = bus.m_valid && bus.m_ready;

  always_comb begin
    bus.m_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_grant && grant_oh_q[i]) bus.m_data = bus.s_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_oh_d = grant_oh_q;
    ptr_d      = ptr_q;
    xfer_cnt_d = xfer_cnt_q;
`ifdef HS_ARB_TIMEOUT_EN
    stall_d       = stall_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          grant_oh_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
`ifdef HS_ARB_TIMEOUT_EN
          stall_d    = '0;
`endif
        end
      end
      GRANT: begin
        if (handshake) begin
          state_d    = IDLE;
          grant_oh_d = '0;
          ptr_d      = gnt_idx;
          xfer_cnt_d = xfer_cnt_q + 8'd1;
        end
`ifdef HS_ARB_TIMEOUT_EN
        // Stuck requester is demoted to lowest priority; its beat is not counted.
        else if (stall_q == 8'(TIMEOUT - 1)) begin
          state_d       = IDLE;
          grant_oh_d    = '0;
          ptr_d         = gnt_idx;
          timeout_err_d = 1'b1;
        end else begin
          stall_d = stall_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      grant_oh_q <= '0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      xfer_cnt_q <= '0;
`ifdef HS_ARB_TIMEOUT_EN
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_oh_q <= grant_oh_d;
      ptr_q      <= ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
`ifdef HS_ARB_TIMEOUT_EN
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant_oh = grant_oh_q;
  assign xfer_cnt = xfer_cnt_q;
`ifdef HS_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule
